key_debounce: RTL and testbench
===============================

# key_debounce

Debounces and synchronizes the board's active-low push-buttons and turns each into a clean level plus one-cycle press/release event pulses. It is the input-side counterpart of the LED drivers: keys in, clean events out. Every other block that reacts to a button consumes these pulses instead of raw pins. Keys are fully independent; one counter and one FSM per key.

## Interface
- `NUM_KEYS`, default 4: number of keys.
- `DEBOUNCE_CNT`, default 1_000_000: consecutive stable samples required to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- `LONG_CNT`, default 50_000_000: cycles after `key_press` before `key_long` fires (1 s at 50 MHz); must be > `DEBOUNCE_CNT`.
- `sys_clk`  input  1  system clock, the only clock in the block.
- `sys_rst`  input  1  reset: synchronous, active-high.
- `key_n`  input  NUM_KEYS  raw key pins, asynchronous, 0 = pressed.
- `key_state`  output  NUM_KEYS  debounced level, 1 = pressed.
- `key_press`  output  NUM_KEYS  one-cycle pulse on an accepted press.
- `key_release`  output  NUM_KEYS  one-cycle pulse on an accepted release.
- `key_long`  output  NUM_KEYS  one-cycle long-press pulse (see Configuration).

## Operation
- Each `key_n[i]` passes through a 2-FF synchronizer, then is inverted to `p[i]` (1 = pressed). The synchronizer FFs reset to 1 (released).
- Per-key FSM with a counter `cnt` of width $clog2(LONG_CNT+1):
  - IDLE: `key_state`=0. If `p`=1, go to PRESS_WAIT with `cnt`=1.
  - PRESS_WAIT: if `p`=0, go to IDLE with `cnt`=0 (a bounce, no pulse). Otherwise, if `cnt`==DEBOUNCE_CNT-1, go to PRESSED, set `key_state`=1, pulse `key_press`, and set `cnt`=0. Otherwise increment `cnt`.
  - PRESSED: `key_state`=1. If `p`=0, go to RELEASE_WAIT. The release-debounce count is held in a separate `rcnt`, same width as a `DEBOUNCE_CNT` counter, set to 1.
  - RELEASE_WAIT: `key_state` stays 1. If `p`=1, return to PRESSED (no pulse). If `rcnt`==DEBOUNCE_CNT-1, go to IDLE, set `key_state`=0, pulse `key_release`, and clear `cnt`. Otherwise increment `rcnt`.
- Keys never interact: any combination may be pressed, released, or pulsed in the same cycle.
- All outputs are registered. No pulse is ever wider than one cycle.
- `cnt` saturates and never wraps.

## Timing
- Reset values: all outputs 0, all FSMs in IDLE, counters 0, synchronizers 1.
- Reset mid-operation: takes effect on the next edge with `sys_rst`=1. No pulse is emitted in or after that cycle. A key still held after reset deasserts must fully re-debounce and then produces a `key_press`.
- Press latency: `key_n[i]` goes low and stays low, first captured at edge E. Then `key_press[i]` and `key_state[i]` rise on edge E+2+DEBOUNCE_CNT.
- Release latency: identical, measured from the first edge capturing `key_n[i]`=1. The outputs are `key_release[i]` and the fall of `key_state[i]`.
- A glitch shorter than DEBOUNCE_CNT cycles produces no event and leaves `key_state` unchanged.
- If a glitch lasts exactly DEBOUNCE_CNT cycles, it is accepted.

## Configuration
- Macro: `KEY_LONGPRESS_EN`.
- Defined:
  - In PRESSED and RELEASE_WAIT, `cnt` increments each cycle, saturating at LONG_CNT.
  - When `cnt` reaches LONG_CNT-1, `key_long[i]` pulses once. This is LONG_CNT cycles after `key_press[i]`.
  - Only one `key_long` pulse per press.
  - A bounce into RELEASE_WAIT and back does not reset `cnt`.
  - If the key is released before then, no pulse is emitted.
- Undefined: the `key_long` port still exists and is driven constant 0. No long counter logic is synthesized, and `cnt` only serves debounce.

## Test plan
Bench parameters: DEBOUNCE_CNT=8, LONG_CNT=32.
- Reset: hold `sys_rst`=1 for 3 cycles with `key_n`=4'b0000. Require all outputs 0 throughout. After release, `key_press`=4'b1111 exactly 10 cycles after the first post-reset capture.
- Clean press: `key_n[0]` goes 1→0 captured at edge E and is held. Require `key_press[0]` high only at E+10 and `key_state[0]`=1 from E+10. Other bits stay 0.
- Bounce: `key_n[1]` low 5 cycles, high 2, low 7, then high. Require no `key_press[1]`, no `key_release[1]`, and `key_state[1]`=0 throughout.
- Release with bounce: key 2 pressed, then `key_n[2]` high 3 cycles, low 1, then high and held. Require a single `key_release[2]` 10 cycles after the final rising capture, and `key_state[2]` falling on that same edge.
- Long press (macro defined): hold key 3. Require `key_long[3]` exactly 32 cycles after `key_press[3]` and only once in 100 cycles. With the macro undefined, `key_long` stays 4'b0000.
- Simultaneous and reset mid-press: press keys 0 and 3 on the same edge and require `key_press`=4'b1001 in one cycle. Then assert `sys_rst` during a held press and require no `key_release`, and a fresh `key_press` 10 cycles after reset drops.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces active-low push-buttons.
// Each key gets a 2-FF synchronizer and a registered polarity flip.
// It also gets its own debounce FSM, which produces a clean level and
// one-cycle press/release pulses.
// Optional feature macro: KEY_LONGPRESS_EN adds a one-shot long-press pulse
// per press. When the macro is not defined, key_long is tied to zero.
module key_debounce #(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CNT = 1_000_000,  // must be >= 2
  parameter int LONG_CNT     = 50_000_000  // must be > DEBOUNCE_CNT
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int CNT_W  = $clog2(LONG_CNT + 1);
  localparam int RCNT_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [RCNT_W-1:0] RDB_LAST = RCNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [RCNT_W-1:0] RCNT_ONE = RCNT_W'(1);
`ifdef KEY_LONGPRESS_EN
  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0]  LONG_MAX  = CNT_W'(LONG_CNT);
`endif

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_REL_WAIT   = 2'd3;

  // Two metastability stages, then a registered inversion to "1 = pressed".
  // The extra stage gives the documented E+2+DEBOUNCE_CNT latency.
  logic [NUM_KEYS-1:0] sync1_reg;
  logic [NUM_KEYS-1:0] sync2_reg;
  logic [NUM_KEYS-1:0] p_reg;

  // Synchronizer idles at "released" so reset never looks like a press.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
      p_reg     <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      p_reg     <= ~sync2_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic              p_i;
      logic [1:0]        state_reg, state_next;
      logic [CNT_W-1:0]  cnt_reg, cnt_next;
      logic [RCNT_W-1:0] rcnt_reg, rcnt_next;
      logic              key_state_reg, key_state_next;
      logic              press_reg, press_next;
      logic              release_reg, release_next;
`ifdef KEY_LONGPRESS_EN
      logic              long_reg, long_next;
`endif

      assign p_i = p_reg[gi];

      // Next-state logic. cnt debounces presses and, optionally, times the
      // long press. rcnt debounces releases, so a release bounce never
      // disturbs the long-press timer.
      always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rcnt_next      = rcnt_reg;
        key_state_next = key_state_reg;
        press_next     = 1'b0;
        release_next   = 1'b0;
`ifdef KEY_LONGPRESS_EN
        long_next      = 1'b0;
`endif
        case (state_reg)
          ST_IDLE: begin
            key_state_next = 1'b0;
            if (p_i) begin
              state_next = ST_PRESS_WAIT;
              cnt_next   = CNT_ONE;
            end
          end
          ST_PRESS_WAIT: begin
            if (!p_i) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == DB_LAST) begin
              state_next     = ST_PRESSED;
              key_state_next = 1'b1;
              press_next     = 1'b1;
              cnt_next       = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          ST_PRESSED: begin
            key_state_next = 1'b1;
            if (!p_i) begin
              state_next = ST_REL_WAIT;
              rcnt_next  = RCNT_ONE;
            end
`ifdef KEY_LONGPRESS_EN
            // Saturating timer; equality with LONG_LAST is hit once per press.
            if (cnt_reg != LONG_MAX) cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LONG_LAST) long_next = 1'b1;
`endif
          end
          ST_REL_WAIT: begin
            key_state_next = 1'b1;
            if (p_i) begin
              state_next = ST_PRESSED;
            end else if (rcnt_reg == RDB_LAST) begin
              state_next     = ST_IDLE;
              key_state_next = 1'b0;
              release_next   = 1'b1;
              cnt_next       = '0;
            end else begin
              rcnt_next = rcnt_reg + 1'b1;
            end
`ifdef KEY_LONGPRESS_EN
            // Keep timing through release bounces.
            // An accepted release cancels the long press.
            if (p_i || (rcnt_reg != RDB_LAST)) begin
              if (cnt_reg != LONG_MAX) cnt_next = cnt_reg + 1'b1;
              if (cnt_reg == LONG_LAST) long_next = 1'b1;
            end
`endif
          end
          default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      // Register FSM, counters and all outputs; reset drops pulses immediately.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          state_reg     <= ST_IDLE;
          cnt_reg       <= '0;
          rcnt_reg      <= '0;
          key_state_reg <= 1'b0;
          press_reg     <= 1'b0;
          release_reg   <= 1'b0;
`ifdef KEY_LONGPRESS_EN
          long_reg      <= 1'b0;
`endif
        end else begin
          state_reg     <= state_next;
          cnt_reg       <= cnt_next;
          rcnt_reg      <= rcnt_next;
          key_state_reg <= key_state_next;
          press_reg     <= press_next;
          release_reg   <= release_next;
`ifdef KEY_LONGPRESS_EN
          long_reg      <= long_next;
`endif
        end
      end

      assign key_state[gi]   = key_state_reg;
      assign key_press[gi]   = press_reg;
      assign key_release[gi] = release_reg;
`ifdef KEY_LONGPRESS_EN
      assign key_long[gi]    = long_reg;
`else
      assign key_long[gi]    = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (DEBOUNCE_CNT=8, LONG_CNT=32).
// A run-length reference model is compared against the DUT every cycle.
// Directed literal checks pin the documented latencies.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 8;
  localparam int LG = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [NK-1:0] key_n   = 4'b1111;
  logic [NK-1:0] key_state, key_press, key_release, key_long;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  key_debounce #(
    .NUM_KEYS    (NK),
    .DEBOUNCE_CNT(DB),
    .LONG_CNT    (LG)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model ----------------
  // lat[k][j]: "pressed" sample seen j+1 edges ago. The FSM acts on the one
  // from 3 edges ago. A level flips after DB consecutive edges that
  // disagree with it. The long pulse is LG edges after an accepted press,
  // if the key is still held.
  bit            lat [NK][3];
  bit            m_state [NK];
  int            run [NK];
  int            age [NK];
  logic [NK-1:0] exp_state = '0, exp_press = '0, exp_rel = '0, exp_long = '0;

  task automatic cmp(input string name, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  always @(posedge sys_clk) begin
    cyc++;
    exp_press = '0;
    exp_rel   = '0;
    exp_long  = '0;
    for (int k = 0; k < NK; k++) begin
      if (sys_rst) begin
        lat[k][0] = 0; lat[k][1] = 0; lat[k][2] = 0;
        m_state[k] = 0; run[k] = 0; age[k] = 0;
      end else begin
        bit p;
        bit just_pressed;
        p = lat[k][2];
        lat[k][2] = lat[k][1];
        lat[k][1] = lat[k][0];
        lat[k][0] = ~key_n[k];
        just_pressed = 0;
        if (p != m_state[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == DB) begin
          m_state[k] = p;
          run[k] = 0;
          if (p) begin
            exp_press[k] = 1'b1;
            age[k] = 0;
            just_pressed = 1;
          end else begin
            exp_rel[k] = 1'b1;
          end
        end
`ifdef KEY_LONGPRESS_EN
        if (m_state[k] && !just_pressed && age[k] <= LG) begin
          age[k]++;
          if (age[k] == LG) exp_long[k] = 1'b1;
        end
`endif
      end
      exp_state[k] = m_state[k];
    end
    #1;
    cmp("model_state",   key_state,   exp_state);
    cmp("model_press",   key_press,   exp_press);
    cmp("model_release", key_release, exp_rel);
    cmp("model_long",    key_long,    exp_long);
  end

  // ---------------- stimulus ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  int hold [NK];

  initial begin
    // Reset with all keys held down: nothing may come out.
    key_n   = 4'b0000;
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_neg(1);
      cmp("rst_outputs", key_state | key_press | key_release | key_long, 4'b0000);
    end
    sys_rst = 1'b0;               // first post-reset capture on next posedge E
    wait_neg(10);                 // after E+9
    cmp("rst_press_early", key_press, 4'b0000);
    wait_neg(1);                  // after E+10
    cmp("rst_press_all", key_press, 4'b1111);
    cmp("rst_state_all", key_state, 4'b1111);
    key_n = 4'b1111;
    wait_neg(20);
    cmp("rst_released", key_state, 4'b0000);

    // Clean press of key 0.
    key_n = 4'b1110;
    wait_neg(10);
    cmp("clean_press_early", key_press, 4'b0000);
    wait_neg(1);
    cmp("clean_press", key_press, 4'b0001);
    cmp("clean_state", key_state, 4'b0001);
    wait_neg(1);
    cmp("clean_press_once", key_press, 4'b0000);
    cmp("clean_state_hold", key_state, 4'b0001);
    key_n = 4'b1111;
    wait_neg(20);

    // Bouncing key 1: low 5, high 2, low 7, high; no event at all.
    for (int i = 0; i < 30; i++) begin
      if (i < 5)       key_n = 4'b1101;
      else if (i < 7)  key_n = 4'b1111;
      else if (i < 14) key_n = 4'b1101;
      else             key_n = 4'b1111;
      wait_neg(1);
      cmp("bounce_key1", {1'b0, key_press[1], key_release[1], key_state[1]}, 4'b0000);
    end

    // Key 2 pressed, then released with a bounce.
    key_n = 4'b1011;
    wait_neg(15);
    cmp("relb_pressed", key_state, 4'b0100);
    key_n = 4'b1111; wait_neg(3);
    key_n = 4'b1011; wait_neg(1);
    key_n = 4'b1111;              // final rising capture on next posedge E
    wait_neg(10);
    cmp("relb_release_early", key_release, 4'b0000);
    cmp("relb_state_held", key_state, 4'b0100);
    wait_neg(1);
    cmp("relb_release", key_release, 4'b0100);
    cmp("relb_state_fall", key_state, 4'b0000);
    wait_neg(1);
    cmp("relb_release_once", key_release, 4'b0000);
    wait_neg(10);

    // Long press of key 3.
    key_n = 4'b0111;
    wait_neg(11);
    cmp("long_press", key_press, 4'b1000);
    wait_neg(31);
    cmp("long_early", key_long, 4'b0000);
    wait_neg(1);
`ifdef KEY_LONGPRESS_EN
    cmp("long_pulse", key_long, 4'b1000);
`else
    cmp("long_pulse", key_long, 4'b0000);
`endif
    for (int i = 0; i < 57; i++) begin
      wait_neg(1);
      cmp("long_once", key_long, 4'b0000);
    end
    key_n = 4'b1111;
    wait_neg(20);

    // Simultaneous press of keys 0 and 3, then reset mid-press.
    key_n = 4'b0110;
    wait_neg(11);
    cmp("simul_press", key_press, 4'b1001);
    wait_neg(5);
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_neg(1);
      cmp("midrst_outputs", key_state | key_press | key_release | key_long, 4'b0000);
    end
    sys_rst = 1'b0;
    wait_neg(10);
    cmp("midrst_no_release", key_release, 4'b0000);
    cmp("midrst_press_early", key_press, 4'b0000);
    wait_neg(1);
    cmp("midrst_repress", key_press, 4'b1001);
    cmp("midrst_state", key_state, 4'b1001);
    key_n = 4'b1111;
    wait_neg(20);

    // Random phase: mixed bounce, exact-threshold and long holds per key.
    for (int k = 0; k < NK; k++) hold[k] = 1;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < NK; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          int r;
          key_n[k] = ~key_n[k];
          r = int'($urandom_range(0, 9));
          if (r < 4)       hold[k] = int'($urandom_range(1, 7));
          else if (r == 4) hold[k] = DB;
          else if (r == 5) hold[k] = DB + 1;
          else             hold[k] = int'($urandom_range(10, 50));
        end
      end
      if ($urandom_range(0, 599) == 0) sys_rst = 1'b1;
      else sys_rst = 1'b0;
      wait_neg(1);
    end
    sys_rst = 1'b0;
    key_n   = 4'b1111;
    wait_neg(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
